mem_line_sequencer: RTL
=======================

# mem_line_sequencer

Downstream completion stage for the execute-side memory join: it consumes the single arbitrated port (Opm/OK request protocol, 128-bit line data) and performs each request as four 32-bit beats on a narrow external req/ack bus. It returns read lines, write completion and bus faults to the join in the Opm/OK protocol. It also times out stalled beats. Only the join drives its upstream port; the external side connects to the narrow memory/ring bridge.

## Interface
Parameters:
- TMO_LIMIT, 255: cycles a beat may wait for ack before a timeout fault (8-bit counter, 1..255).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- memOutData  in  128  write line from the join.
- memAddrA  in  48  line address; bits [3:0] ignored.
- memAddrB  in  48  unused, reserved.
- memOpm  in  5  request opcode. [4:3]=00 READY/idle, 01 read, 10 write, 11 illegal.
- memInData  out  128  read line. Reset 0.
- memOK  out  2  response: READY=0, OK=1, HOLD=2, FAULT=3. Reset READY.
- memBusExc  out  64  fault record {code[15:0], addr[47:0]}. Reset 0.
- extReq  out  1  beat request. Reset 0.
- extWe  out  1  beat is a write. Reset 0.
- extAddr  out  48  beat byte address. Reset 0.
- extWData  out  32  beat write data. Reset 0.
- extRData  in  32  beat read data, valid with extAck.
- extAck  in  1  beat complete, sampled on clock edges only while extReq=1.
- extErr  in  1  beat error, valid with extAck.

## Operation
- States: IDLE, BEAT, DONE, FAULT.
- IDLE:
  - memOpm READY: memOK=READY.
  - memOpm read/write: latch addr[47:4], data and direction; beat counter=0, timeout counter=0; go to BEAT. memOK=HOLD.
  - memOpm illegal (11): go to FAULT with code 16'h8002.
- BEAT:
  - extReq=1. extAddr={addr[47:4], beat[1:0], 2'b00}. extWData=memOutData[32*beat +: 32]. memOK=HOLD.
  - On extAck with !extErr: reads store extRData into memInData[32*beat +: 32]. If beat=3, go to DONE; else beat+1 and clear the timeout counter.
  - On extAck with extErr: code 16'h8000, go to FAULT; remaining beats are abandoned.
  - No ack while the counter reaches TMO_LIMIT: code 16'h8001, go to FAULT.
- DONE: memOK=OK. Hold until memOpm=READY, then go to IDLE (memOK=READY the same edge).
- FAULT: memOK=FAULT. memBusExc={code, addr[47:4], 4'h0}. Hold until memOpm=READY, then go to IDLE. memBusExc clears on IDLE entry.
- Reads: memInData updates per beat and is stable from DONE until the next request's first ack.
- Writes: memInData unchanged.
- Requests are not re-sampled until IDLE. A changed Opm or address mid-request is ignored.

## Timing
- All outputs are registered.
- Request sampled in IDLE at edge N: extReq=1 and memOK=HOLD from N+1.
- Back-to-back beats: extReq stays high across beats. extAddr/extWData advance on the edge that samples ack.
- Zero-wait acks: beats at N+1..N+4, memOK=OK at N+5, extReq low at N+5.
- Minimum turnaround: memOpm=READY seen at edge M in DONE/FAULT gives memOK=READY at M+1. A new request can be sampled at M+1, giving memOK=HOLD at M+2.
- Timeout: fault raised TMO_LIMIT cycles after the beat's request (or its last ack), with no ack.
- Simultaneous extAck and timeout expiry: the ack wins.
- Reset asserted mid-beat: all outputs go to reset values immediately, the state goes to IDLE, and the in-flight beat is dropped. The external side must tolerate an unacked request withdrawal under reset.

## Structure
- Shared memory-protocol package holds:
  - UMEM_OPM_* and UMEM_OK_* codes.
  - Fault codes 8000/8001/8002.
  - The state enum.
- Single flat module. No sub-module is needed; the beat/timeout counters are inline.

## Test plan
- Read at addr 0x0000_1234_5670, zero-wait acks returning 0x11111111, 0x22222222, 0x33333333, 0x44444444 → extAddr ...5670/4/8/C, memInData=0x44444444_33333333_22222222_11111111, memOK=OK at N+5, then READY one cycle after Opm drops.
- Write of 0xDDDD..._AAAA... with 3-cycle ack delay per beat → extWe=1, extWData lanes in order 0..3, extReq held throughout, memOK=OK after the fourth ack.
- extErr on beat 2 of a read at 0x40 → no beat 3, memOK=FAULT, memBusExc=0x8000_0000_0000_0040.
- No ack, TMO_LIMIT=16 → FAULT with code 0x8001 exactly 16 cycles after extReq rises. A late ack afterwards is ignored.
- Opm=5'b11000 → FAULT with code 0x8002, no extReq. After Opm=READY, memOK=READY.
- Reset pulsed mid-beat 1 → extReq, memOK and memBusExc are 0 asynchronously. After release, a fresh read completes normally.

Source files
------------

// File: rtl/mem_line_sequencer_pkg.sv
// Shared memory-protocol definitions: Opm/OK codes, bus fault codes and the
// line sequencer state encoding.
package mem_line_sequencer_pkg;

  localparam logic [1:0] UMEM_OPM_READY   = 2'b00;
  localparam logic [1:0] UMEM_OPM_READ    = 2'b01;
  localparam logic [1:0] UMEM_OPM_WRITE   = 2'b10;
  localparam logic [1:0] UMEM_OPM_ILLEGAL = 2'b11;

  localparam logic [1:0] UMEM_OK_READY = 2'd0;
  localparam logic [1:0] UMEM_OK_OK    = 2'd1;
  localparam logic [1:0] UMEM_OK_HOLD  = 2'd2;
  localparam logic [1:0] UMEM_OK_FAULT = 2'd3;

  localparam logic [15:0] FLT_EXT_ERR     = 16'h8000;
  localparam logic [15:0] FLT_TIMEOUT     = 16'h8001;
  localparam logic [15:0] FLT_ILLEGAL_OPM = 16'h8002;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT  = 2'd1,
    ST_DONE  = 2'd2,
    ST_FAULT = 2'd3
  } seqState_t;

endpackage

// File: rtl/mem_line_sequencer_if.sv
// Bundles the join-facing Opm/OK port and the narrow external req/ack bus.
interface mem_line_sequencer_if;

  logic [127:0] memOutData;
  logic [47:0]  memAddrA;
  logic [47:0]  memAddrB;
  logic [4:0]   memOpm;
  logic [127:0] memInData;
  logic [1:0]   memOK;
  logic [63:0]  memBusExc;

  logic         extReq;
  logic         extWe;
  logic [47:0]  extAddr;
  logic [31:0]  extWData;
  logic [31:0]  extRData;
  logic         extAck;
  logic         extErr;

  modport master (
    output memOutData, memAddrA, memAddrB, memOpm, extRData, extAck, extErr,
    input  memInData, memOK, memBusExc, extReq, extWe, extAddr, extWData
  );

  modport slave (
    input  memOutData, memAddrA, memAddrB, memOpm, extRData, extAck, extErr,
    output memInData, memOK, memBusExc, extReq, extWe, extAddr, extWData
  );

endinterface

// File: rtl/mem_line_sequencer.sv
// Splits each 128-bit line request into four 32-bit req/ack beats with a
// per-beat timeout; every output is a register fed from the next-state logic.
module mem_line_sequencer
  import mem_line_sequencer_pkg::*;
#(
  parameter int TMO_LIMIT = 255
) (
  input logic                 clock,
  input logic                 reset,
  mem_line_sequencer_if.slave bus
);

  localparam logic [7:0] TMO_LAST = 8'(TMO_LIMIT - 1);

  seqState_t    state, stateNext;
  logic [1:0]   beatCnt, beatNext, beatInc;
  logic [7:0]   tmoCnt, tmoNext;
  logic [43:0]  lineAddr, lineAddrNext;
  logic [127:0] lineData, lineDataNext;
  logic         isWrite, isWriteNext;

  logic [127:0] memInDataQ, inDataNext;
  logic [1:0]   memOKQ, okNext;
  logic [63:0]  memBusExcQ, excNext;
  logic         extReqQ, reqNext;
  logic         extWeQ, weNext;
  logic [47:0]  extAddrQ, addrNext;
  logic [31:0]  extWDataQ, wdataNext;

  logic unusedBits;
  assign unusedBits = ^{bus.memAddrB, bus.memAddrA[3:0], bus.memOpm[2:0]};

  assign bus.memInData = memInDataQ;
  assign bus.memOK     = memOKQ;
  assign bus.memBusExc = memBusExcQ;
  assign bus.extReq    = extReqQ;
  assign bus.extWe     = extWeQ;
  assign bus.extAddr   = extAddrQ;
  assign bus.extWData  = extWDataQ;

  assign beatInc = beatCnt + 2'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      beatCnt    <= 2'd0;
      tmoCnt     <= 8'd0;
      isWrite    <= 1'b0;
      memInDataQ <= '0;
      memOKQ     <= UMEM_OK_READY;
      memBusExcQ <= '0;
      extReqQ    <= 1'b0;
      extWeQ     <= 1'b0;
      extAddrQ   <= '0;
      extWDataQ  <= '0;
    end else begin
      state      <= stateNext;
      beatCnt    <= beatNext;
      tmoCnt     <= tmoNext;
      isWrite    <= isWriteNext;
      memInDataQ <= inDataNext;
      memOKQ     <= okNext;
      memBusExcQ <= excNext;
      extReqQ    <= reqNext;
      extWeQ     <= weNext;
      extAddrQ   <= addrNext;
      extWDataQ  <= wdataNext;
    end
  end

  // Request line latches hold payload only; they need no reset.
  always_ff @(posedge clock) begin
    lineAddr <= lineAddrNext;
    lineData <= lineDataNext;
  end

  always_comb begin
    stateNext    = state;
    beatNext     = beatCnt;
    tmoNext      = tmoCnt;
    lineAddrNext = lineAddr;
    lineDataNext = lineData;
    isWriteNext  = isWrite;
    inDataNext   = memInDataQ;
    okNext       = memOKQ;
    excNext      = memBusExcQ;
    reqNext      = 1'b0;
    weNext       = 1'b0;
    addrNext     = extAddrQ;
    wdataNext    = extWDataQ;

    unique case (state)
      ST_IDLE: begin
        okNext = UMEM_OK_READY;
        unique case (bus.memOpm[4:3])
          UMEM_OPM_READ, UMEM_OPM_WRITE: begin
            lineAddrNext = bus.memAddrA[47:4];
            lineDataNext = bus.memOutData;
            isWriteNext  = (bus.memOpm[4:3] == UMEM_OPM_WRITE);
            beatNext     = 2'd0;
            tmoNext      = 8'd0;
            stateNext    = ST_BEAT;
            okNext       = UMEM_OK_HOLD;
            reqNext      = 1'b1;
            weNext       = (bus.memOpm[4:3] == UMEM_OPM_WRITE);
            addrNext     = {bus.memAddrA[47:4], 4'h0};
            wdataNext    = bus.memOutData[31:0];
          end
          UMEM_OPM_ILLEGAL: begin
            stateNext = ST_FAULT;
            okNext    = UMEM_OK_FAULT;
            excNext   = {FLT_ILLEGAL_OPM, bus.memAddrA[47:4], 4'h0};
          end
          default: ;
        endcase
      end

      ST_BEAT: begin
        okNext  = UMEM_OK_HOLD;
        reqNext = 1'b1;
        weNext  = isWrite;
        // An ack in the expiry cycle still completes the beat.
        if (bus.extAck) begin
          if (bus.extErr) begin
            stateNext = ST_FAULT;
            okNext    = UMEM_OK_FAULT;
            reqNext   = 1'b0;
            weNext    = 1'b0;
            excNext   = {FLT_EXT_ERR, lineAddr, 4'h0};
          end else begin
            if (!isWrite) inDataNext[32*beatCnt +: 32] = bus.extRData;
            if (beatCnt == 2'd3) begin
              stateNext = ST_DONE;
              okNext    = UMEM_OK_OK;
              reqNext   = 1'b0;
              weNext    = 1'b0;
            end else begin
              beatNext  = beatInc;
              tmoNext   = 8'd0;
              addrNext  = {lineAddr, beatInc, 2'b00};
              wdataNext = lineData[32*beatInc +: 32];
            end
          end
        end else if (tmoCnt == TMO_LAST) begin
          stateNext = ST_FAULT;
          okNext    = UMEM_OK_FAULT;
          reqNext   = 1'b0;
          weNext    = 1'b0;
          excNext   = {FLT_TIMEOUT, lineAddr, 4'h0};
        end else begin
          tmoNext = tmoCnt + 8'd1;
        end
      end

      ST_DONE: begin
        okNext = UMEM_OK_OK;
        if (bus.memOpm[4:3] == UMEM_OPM_READY) begin
          stateNext = ST_IDLE;
          okNext    = UMEM_OK_READY;
        end
      end

      ST_FAULT: begin
        okNext = UMEM_OK_FAULT;
        if (bus.memOpm[4:3] == UMEM_OPM_READY) begin
          stateNext = ST_IDLE;
          okNext    = UMEM_OK_READY;
          excNext   = '0;
        end
      end

      default: stateNext = ST_IDLE;
    endcase
  end

endmodule
